// File: rtl/uart_pkg.sv
// Shared types, defaults and the round-robin pick function for the UART TX scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } sched_state_t;

  localparam int DEFAULT_MAX_BURST   = 16;
  localparam int DEFAULT_TIMEOUT_CYC = 20000;
  localparam int MAX_REQ             = 8;

  // First requester with req high, scanning last_owner+1 .. last_owner+n (mod n).
  // Descending scan so the nearest candidate is the one left in pick.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last_owner,
                                         input int                 n);
    logic [2:0] pick;
    int         idx;
    pick = last_owner;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last_owner) + k) % n;
        if (req[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select; the last_owner register lives in the parent.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last_owner,
  output logic         valid,
  output logic [2:0]   pick
);

  logic [MAX_REQ-1:0] req_ext;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    valid          = |req;
    pick           = rr_pick(req_ext, last_owner, N);
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N byte-stream requesters,
// holding a grant across a packet up to MAX_BURST bytes, with a per-byte timeout.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N           = 4,
  parameter int MAX_BURST   = DEFAULT_MAX_BURST,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic [2:0]     grant_id,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_busy,
  input  logic           tx_done,
  output logic           timeout_err
);

  localparam logic [7:0]  BURST_LIMIT   = 8'(MAX_BURST);
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYC);

  sched_state_t state_q, state_d;
  logic [2:0]   owner_q, owner_d;
  logic [2:0]   last_owner_q, last_owner_d;
  logic [7:0]   burst_q, burst_d;
  logic         last_flag_q, last_flag_d;
  logic [31:0]  tmo_q, tmo_d, tmo_inc;
  logic [N-1:0] grant_d, ack_d;
  logic [7:0]   tx_data_d;
  logic         tx_start_d, timeout_err_d, release_grant;
  logic         arb_valid;
  logic [2:0]   arb_pick;
  logic         owner_req, owner_last;
  logic [7:0]   owner_byte;

  function automatic logic [N-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    for (int i = 0; i < N; i++) if (idx == 3'(i)) onehot[i] = 1'b1;
  endfunction

  rr_arbiter #(.N(N)) u_arb (
    .req       (req),
    .last_owner(last_owner_q),
    .valid     (arb_valid),
    .pick      (arb_pick)
  );

  assign grant_id = owner_q;

  // Current owner's request lines, selected without out-of-range indexing.
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == 3'(i)) begin
        owner_req  = req[i];
        owner_last = req_last[i];
        owner_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    burst_d       = burst_q;
    last_flag_d   = last_flag_q;
    tmo_d         = tmo_q;
    grant_d       = grant;
    tx_data_d     = tx_data;
    tx_start_d    = 1'b0;
    ack_d         = '0;
    timeout_err_d = 1'b0;
    release_grant = 1'b0;
    tmo_inc       = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_pick;
          grant_d = onehot(arb_pick);
          burst_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!owner_req) begin
          release_grant = 1'b1;
        end else if (!tx_busy) begin
          tx_start_d  = 1'b1;
          tx_data_d   = owner_byte;
          ack_d       = onehot(owner_q);
          last_flag_d = owner_last;
          burst_d     = burst_q + 8'd1;
          tmo_d       = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        tmo_d = tmo_inc;
        // tx_done wins over a timeout terminal count in the same cycle.
        if (tx_done) begin
          if (last_flag_q || burst_q == BURST_LIMIT || !owner_req) release_grant = 1'b1;
          else state_d = LOAD;
        end else if (tmo_inc >= TIMEOUT_LIMIT) begin
          timeout_err_d = 1'b1;
          release_grant = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_grant) begin
      grant_d      = '0;
      last_owner_d = owner_q;
      state_d      = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= 3'(N - 1);
      burst_q      <= '0;
      last_flag_q  <= 1'b0;
      tmo_q        <= '0;
      grant        <= '0;
      ack          <= '0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      last_flag_q  <= last_flag_d;
      tmo_q        <= tmo_d;
      grant        <= grant_d;
      ack          <= ack_d;
      tx_start     <= tx_start_d;
      tx_data      <= tx_data_d;
      timeout_err  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: two scheduler instances (MAX_BURST 16 and 2, TIMEOUT_CYC 50) with
// queue-driven requesters and a simple UART TX model behind each.
module tb_uart_tx_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]   req[2]       = '{default: '0};
  logic [N-1:0]   req_last[2]  = '{default: '0};
  logic [8*N-1:0] req_data[2]  = '{default: '0};
  logic [N-1:0]   ack[2];
  logic [N-1:0]   grant[2];
  logic [2:0]     grant_id[2];
  logic           tx_start[2];
  logic [7:0]     tx_data[2];
  logic           tx_busy[2]   = '{default: 1'b0};
  logic           tx_done[2]   = '{default: 1'b0};
  logic           timeout_err[2];

  // Requester byte queues: {last, data}; tail written by tests, head by the requester model.
  logic [8:0] qmem[2][4][64] = '{default: '0};
  int         qhead[2][4]    = '{default: 0};
  int         qtail[2][4]    = '{default: 0};

  // TX model controls and observation logs.
  int         dly[2]         = '{10, 10};
  logic       done_en[2]     = '{1'b1, 1'b1};
  int         tx_cnt[2]      = '{0, 0};
  logic [2:0] log_id[2][64];
  logic [7:0] log_dat[2][64];
  int         log_n[2]       = '{0, 0};
  int         inv_bad[2]     = '{0, 0};
  int         to_n[2]        = '{0, 0};

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler #(.N(N), .MAX_BURST(16), .TIMEOUT_CYC(50)) dut_a (
    .clk(clk), .rst(rst), .req(req[0]), .req_data(req_data[0]), .req_last(req_last[0]),
    .ack(ack[0]), .grant(grant[0]), .grant_id(grant_id[0]), .tx_start(tx_start[0]),
    .tx_data(tx_data[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]),
    .timeout_err(timeout_err[0])
  );

  uart_tx_scheduler #(.N(N), .MAX_BURST(2), .TIMEOUT_CYC(50)) dut_b (
    .clk(clk), .rst(rst), .req(req[1]), .req_data(req_data[1]), .req_last(req_last[1]),
    .ack(ack[1]), .grant(grant[1]), .grant_id(grant_id[1]), .tx_start(tx_start[1]),
    .tx_data(tx_data[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]),
    .timeout_err(timeout_err[1])
  );

  always #5 clk = ~clk;

  // Monitor, TX model and requester model, all on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (tx_start[d] && log_n[d] < 64) begin
        log_id[d][log_n[d]]  = grant_id[d];
        log_dat[d][log_n[d]] = tx_data[d];
        log_n[d]++;
      end
      if ((ack[d] != '0 || tx_start[d]) && !(tx_start[d] && ack[d] == (4'b0001 << grant_id[d])))
        inv_bad[d]++;
      if (timeout_err[d]) to_n[d]++;

      tx_done[d] = 1'b0;
      if (tx_start[d]) begin
        tx_busy[d] = 1'b1;
        tx_cnt[d]  = dly[d];
      end else if (tx_busy[d]) begin
        if (tx_cnt[d] > 1) tx_cnt[d]--;
        else begin
          tx_busy[d] = 1'b0;
          tx_done[d] = done_en[d];
        end
      end

      for (int r = 0; r < N; r++) begin
        if (ack[d][r] && qhead[d][r] < qtail[d][r]) qhead[d][r]++;
        req[d][r]           = qhead[d][r] < qtail[d][r];
        req_data[d][8*r +: 8] = qmem[d][r][qhead[d][r]][7:0];
        req_last[d][r]      = qmem[d][r][qhead[d][r]][8];
      end
    end
  end

  task automatic push(input int d, input int r, input logic [7:0] b, input logic l);
    qmem[d][r][qtail[d][r]] = {l, b};
    qtail[d][r]             = qtail[d][r] + 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int d, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = grant[d] == '0 && !tx_busy[d];
      for (int r = 0; r < N; r++) if (qhead[d][r] != qtail[d][r]) done = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s idle_timeout grant %b busy %b", name, grant[d], tx_busy[d]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input int d, input string name);
    int i;
    for (i = 0; i < 40 && !tx_start[d]; i++) @(negedge clk);
    if (!tx_start[d]) begin
      checks++;
      errors++;
      $display("FAIL %s start_timeout tx_start %b want 1", name, tx_start[d]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({grant[d], grant_id[d], ack[d], tx_start[d], tx_data[d], timeout_err[d]} !== '0) begin
        errors++;
        $display("FAIL reset_values dut%0d got grant %b id %0d ack %b start %b data %h terr %b want all 0",
                 d, grant[d], grant_id[d], ack[d], tx_start[d], tx_data[d], timeout_err[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    push(0, 0, 8'hA5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant[0] !== 4'b0001 || tx_start[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got grant %b start %b want 0001 0", grant[0], tx_start[0]);
    end
    @(negedge clk);
    checks++;
    if (tx_start[0] !== 1'b1 || ack[0] !== 4'b0001 || grant_id[0] !== 3'd0) begin
      errors++;
      $display("FAIL single_start got start %b ack %b id %0d want 1 0001 0", tx_start[0], ack[0], grant_id[0]);
    end
    checks++;
    if (tx_data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_data got %h want a5", tx_data[0]);
    end
    @(negedge clk);
    checks++;
    if (tx_start[0] !== 1'b0 || ack[0] !== 4'b0000) begin
      errors++;
      $display("FAIL single_pulse got start %b ack %b want 0 0000", tx_start[0], ack[0]);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (grant[0] !== 4'b0001 || tx_data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold got grant %b data %h want 0001 a5", grant[0], tx_data[0]);
    end
    @(negedge clk);
    checks++;
    if (grant[0] !== 4'b0000) begin
      errors++;
      $display("FAIL single_release got grant %b want 0000", grant[0]);
    end
    wait_idle(0, "single");
  endtask

  task automatic test_fairness();
    int base;
    int exp_id[8]  = '{0, 1, 2, 3, 0, 2, 0, 2};
    int exp_dat[8] = '{'h10, 'h11, 'h12, 'h13, 'h10, 'h22, 'h20, 'h23};
    apply_reset();
    base = log_n[0];
    @(posedge clk); #1;
    push(0, 0, 8'h10, 1'b1); push(0, 0, 8'h10, 1'b1);
    push(0, 1, 8'h11, 1'b1); push(0, 2, 8'h12, 1'b1); push(0, 3, 8'h13, 1'b1);
    wait_idle(0, "fair_round1");
    @(posedge clk); #1;
    push(0, 0, 8'h20, 1'b1); push(0, 2, 8'h22, 1'b1); push(0, 2, 8'h23, 1'b1);
    wait_idle(0, "fair_round2");
    checks++;
    if (log_n[0] - base !== 8) begin
      errors++;
      $display("FAIL fair_count got %0d want 8", log_n[0] - base);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (int'(log_id[0][base+i]) !== exp_id[i] || int'(log_dat[0][base+i]) !== exp_dat[i]) begin
        errors++;
        $display("FAIL fair_order[%0d] got id %0d data %h want id %0d data %h",
                 i, log_id[0][base+i], log_dat[0][base+i], exp_id[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_packet_hold();
    int base;
    int exp_id[4]  = '{1, 1, 1, 2};
    int exp_dat[4] = '{'h30, 'h31, 'h32, 'h40};
    base = log_n[0];
    @(posedge clk); #1;
    push(0, 1, 8'h30, 1'b0); push(0, 1, 8'h31, 1'b0); push(0, 1, 8'h32, 1'b1);
    push(0, 2, 8'h40, 1'b1);
    wait_idle(0, "packet");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(log_id[0][base+i]) !== exp_id[i] || int'(log_dat[0][base+i]) !== exp_dat[i]) begin
        errors++;
        $display("FAIL packet_order[%0d] got id %0d data %h want id %0d data %h",
                 i, log_id[0][base+i], log_dat[0][base+i], exp_id[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_burst_limit();
    int base;
    int exp_id[6]  = '{0, 0, 3, 0, 0, 0};
    int exp_dat[6] = '{'h50, 'h51, 'h60, 'h52, 'h53, 'h54};
    base = log_n[1];
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(1, 0, 8'(8'h50 + i), 1'b0);
    push(1, 3, 8'h60, 1'b1);
    wait_idle(1, "burst");
    checks++;
    if (log_n[1] - base !== 6) begin
      errors++;
      $display("FAIL burst_count got %0d want 6", log_n[1] - base);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (int'(log_id[1][base+i]) !== exp_id[i] || int'(log_dat[1][base+i]) !== exp_dat[i]) begin
        errors++;
        $display("FAIL burst_order[%0d] got id %0d data %h want id %0d data %h",
                 i, log_id[1][base+i], log_dat[1][base+i], exp_id[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int to_base;
    done_en[0] = 1'b0;
    @(posedge clk); #1;
    push(0, 0, 8'h55, 1'b1);
    wait_start(0, "timeout");
    n = 0;
    while (n < 100 && timeout_err[0] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 50) begin
      errors++;
      $display("FAIL timeout_latency got %0d want 50", n);
    end
    checks++;
    if (grant[0] !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_release got grant %b want 0000", grant[0]);
    end
    @(negedge clk);
    checks++;
    if (timeout_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got %b want 0", timeout_err[0]);
    end
    done_en[0] = 1'b1;
    wait_idle(0, "timeout");

    // tx_done lands on the terminal-count cycle: done wins, no timeout_err.
    dly[0]  = 49;
    to_base = to_n[0];
    @(posedge clk); #1;
    push(0, 0, 8'h56, 1'b1);
    wait_idle(0, "coincide");
    checks++;
    if (to_n[0] - to_base !== 0) begin
      errors++;
      $display("FAIL coincide_no_timeout got %0d pulses want 0", to_n[0] - to_base);
    end

    // tx_done one cycle late: timeout fires, the stray done in IDLE is ignored.
    dly[0]  = 50;
    to_base = to_n[0];
    n       = log_n[0];
    @(posedge clk); #1;
    push(0, 0, 8'h57, 1'b1);
    wait_idle(0, "late_done");
    checks++;
    if (to_n[0] - to_base !== 1 || log_n[0] - n !== 1) begin
      errors++;
      $display("FAIL late_done got %0d pulses %0d starts want 1 1", to_n[0] - to_base, log_n[0] - n);
    end
    dly[0] = 10;
  endtask

  task automatic test_reset_mid();
    int base;
    dly[0] = 30;
    @(posedge clk); #1;
    push(0, 2, 8'h70, 1'b1);
    wait_start(0, "rst_mid");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant[0], grant_id[0], ack[0], tx_start[0], tx_data[0], timeout_err[0]} !== '0) begin
      errors++;
      $display("FAIL rst_mid_values got grant %b id %0d ack %b start %b data %h terr %b want all 0",
               grant[0], grant_id[0], ack[0], tx_start[0], tx_data[0], timeout_err[0]);
    end
    rst    = 1'b0;
    base   = log_n[0];
    wait_idle(0, "rst_mid_drain");
    checks++;
    if (grant[0] !== 4'b0000 || log_n[0] !== base) begin
      errors++;
      $display("FAIL rst_mid_stray_done got grant %b starts %0d want 0000 0", grant[0], log_n[0] - base);
    end
    dly[0] = 10;
    @(posedge clk); #1;
    push(0, 0, 8'h71, 1'b1);
    push(0, 1, 8'h72, 1'b1);
    wait_idle(0, "rst_mid_after");
    checks++;
    if (log_id[0][base] !== 3'd0 || log_dat[0][base] !== 8'h71 || log_id[0][base+1] !== 3'd1) begin
      errors++;
      $display("FAIL rst_mid_priority got first id %0d data %h second id %0d want 0 71 1",
               log_id[0][base], log_dat[0][base], log_id[0][base+1]);
    end
  endtask

  task automatic test_invariants();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (inv_bad[d] !== 0) begin
        errors++;
        $display("FAIL ack_invariant dut%0d got %0d bad cycles want 0", d, inv_bad[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_packet_hold();
    test_burst_limit();
    test_timeout();
    test_reset_mid();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
